// File: rtl/dmem_dump_arbiter.sv
// Data-memory port arbiter: passes CPU accesses through in IDLE, otherwise stalls the
// CPU and streams every memory word out over a valid/ready dump port.
module dmem_dump_arbiter #(
  parameter  int N     = 64,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         dump_req,
  input  logic [N-1:0] cpu_addr,
  input  logic [N-1:0] cpu_wdata,
  input  logic         cpu_we,
  output logic [N-1:0] cpu_rdata,
  output logic         cpu_stall,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_we,
  input  logic [N-1:0] mem_rdata,
  output logic         dump_valid,
  input  logic         dump_ready,
  output logic [N-1:0] dump_data,
  output logic [N-1:0] dump_addr,
  output logic         dump_busy,
  output logic         dump_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t         r_state;
  logic [AW-1:0]  r_idx;
  logic [N-1:0]   r_dump_data;
  logic [N-1:0]   r_dump_addr;
  logic           r_dump_valid;
  logic           r_dump_busy;
  logic           r_dump_done;
  logic           r_cpu_stall;

  logic           w_idle;
  logic [N-1:0]   w_idx_addr;

  assign w_idle     = (r_state == S_IDLE);
  assign w_idx_addr = N'({r_idx, 3'b000});

  // The CPU owns the memory port only in IDLE; writes are also gated by reset.
  assign mem_addr  = w_idle ? cpu_addr  : w_idx_addr;
  assign mem_wdata = w_idle ? cpu_wdata : '0;
  assign mem_we    = w_idle & cpu_we & reset;
  assign cpu_rdata = mem_rdata;

  assign cpu_stall  = r_cpu_stall;
  assign dump_valid = r_dump_valid;
  assign dump_busy  = r_dump_busy;
  assign dump_done  = r_dump_done;
  assign dump_data  = r_dump_data;
  assign dump_addr  = r_dump_addr;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_dump_data  <= '0;
      r_dump_addr  <= '0;
      r_dump_valid <= 1'b0;
      r_dump_busy  <= 1'b0;
      r_dump_done  <= 1'b0;
      r_cpu_stall  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dump_req) begin
            r_state     <= S_RD;
            r_idx       <= '0;
            r_dump_busy <= 1'b1;
            r_cpu_stall <= 1'b1;
          end
        end
        S_RD: begin
          r_state <= S_CAP;
        end
        S_CAP: begin
          // Memory has one cycle of read latency, so the word for r_idx arrives here.
          r_dump_data  <= mem_rdata;
          r_dump_addr  <= w_idx_addr;
          r_dump_valid <= 1'b1;
          r_state      <= S_OUT;
        end
        S_OUT: begin
          if (dump_ready) begin
            r_dump_valid <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_state     <= S_DONE;
              r_dump_done <= 1'b1;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_RD;
            end
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_idx       <= '0;
          r_dump_done <= 1'b0;
          r_dump_busy <= 1'b0;
          r_cpu_stall <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_idx        <= '0;
          r_dump_valid <= 1'b0;
          r_dump_done  <= 1'b0;
          r_dump_busy  <= 1'b0;
          r_cpu_stall  <= 1'b0;
        end
      endcase
    end
  end

endmodule
